alu_seq_ctrl: RTL

Request/response front end that drives the 8-bit ALU port set (InputA, InputB, OP, SC_in, imm) and collects Out/Zero/OutBit/Parity. It owns the architectural shift-carry (SC) register and turns LSH into a multi-cycle N-bit shift built from single-bit ALU LSH steps. It sits between the decode/issue logic and the ALU. The ALU stays purely combinational; all sequencing and result holding is done here.

---
 rtl/alu_seq_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: request/response sequencer in front of a combinational 8-bit ALU.
// Owns the shift-carry (SC) register and expands LSH by N into N single-bit
// ALU LSH steps. Results are held in RESP until the consumer takes them.
// Optional macro ALU_SEQ_OVERLAP_EN: accept a new request on the same edge as
// the response handshake (RESP -> EXEC), giving 1 result per 2 cycles.
module alu_seq_ctrl #(
  parameter int   DW       = 8,
  parameter logic SC_INIT  = 1'b0,
  parameter logic LSH_FILL = 1'b0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          ReqValid,
  output logic          ReqReady,
  input  logic [DW-1:0] ReqA,
  input  logic [DW-1:0] ReqB,
  input  logic [3:0]    ReqOp,
  input  logic [2:0]    ReqImm,
  output logic [DW-1:0] AluA,
  output logic [DW-1:0] AluB,
  output logic [3:0]    AluOp,
  output logic          AluSC,
  output logic [2:0]    AluImm,
  input  logic [DW-1:0] AluOut,
  input  logic          AluZero,
  input  logic          AluOutBit,
  input  logic          AluParity,
  output logic          RspValid,
  input  logic          RspReady,
  output logic [DW-1:0] RspData,
  output logic          RspZero,
  output logic          RspFlag,
  output logic          SC,
  output logic          Busy
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_LSH  = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_CPY  = 4'b0101;
  localparam logic [3:0] OP_GETB = 4'b0110;
  localparam logic [3:0] OP_SETB = 4'b1000;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] op_a, op_b, acc;
  logic [3:0]    op;
  logic [2:0]    imm;
  logic [2:0]    cnt;
  logic          sc;
  logic [DW-1:0] rsp_data;
  logic          rsp_zero, rsp_flag;
  logic          accept, lsh_step, last_step;
  logic [DW:0]   add_sum;

  assign accept    = ReqValid & ReqReady;
  // Only LSH with a non-zero count runs real shift steps; LSH by 0 is a copy.
  assign lsh_step  = (op == OP_LSH) && (imm != 3'd0);
  assign last_step = (cnt == 3'd1);
  assign add_sum   = {1'b0, op_a} + {1'b0, op_b};

  assign RspValid = (state == S_RESP);
  assign Busy     = (state != S_IDLE);
  assign RspData  = rsp_data;
  assign RspZero  = rsp_zero;
  assign RspFlag  = rsp_flag;
  assign SC       = sc;
  assign AluA     = lsh_step ? acc : op_a;
  assign AluB     = op_b;
  assign AluImm   = imm;
  assign AluSC    = lsh_step ? LSH_FILL : sc;

  // Opcode steering: LSH-by-0 and undefined opcodes run as a plain copy.
  always_comb begin
    AluOp = OP_CPY;
    if (lsh_step)
      AluOp = OP_LSH;
    else if (op != OP_LSH && op <= OP_SETB)
      AluOp = op;
  end

  // Request acceptance and next-state selection.
  always_comb begin
`ifdef ALU_SEQ_OVERLAP_EN
    ReqReady = ((state == S_IDLE) || ((state == S_RESP) && RspReady)) && !Reset;
`else
    ReqReady = (state == S_IDLE) && !Reset;
`endif
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_EXEC;
      S_EXEC:  if (last_step) state_nxt = S_RESP;
      S_RESP:  if (RspReady) state_nxt = accept ? S_EXEC : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Operand capture, shift sequencing, SC update and result holding.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      op_a     <= '0;
      op_b     <= '0;
      op       <= '0;
      imm      <= '0;
      acc      <= '0;
      cnt      <= '0;
      sc       <= SC_INIT;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_flag <= 1'b0;
    end else if (accept) begin
      op_a <= ReqA;
      op_b <= ReqB;
      op   <= ReqOp;
      imm  <= ReqImm;
      acc  <= ReqA;
      cnt  <= (ReqOp == OP_LSH && ReqImm != 3'd0) ? ReqImm : 3'd1;
    end else if (state == S_EXEC) begin
      cnt <= cnt - 3'd1;
      if (lsh_step) begin
        acc <= AluOut;
        sc  <= acc[DW-1];
        if (last_step) begin
          rsp_data <= AluOut;
          rsp_zero <= (AluOut == '0);
          rsp_flag <= 1'b0;
        end
      end else begin
        rsp_data <= AluOut;
        rsp_zero <= AluZero;
        rsp_flag <= (op == OP_XOR) ? AluParity :
                    (op == OP_GETB) ? AluOutBit : 1'b0;
        if (op == OP_ADD)
          sc <= add_sum[DW];
        else if (op == OP_GETB)
          sc <= AluOutBit;
      end
    end
  end

endmodule
